// File: rtl/sr_flop_bank.sv
// Bank of independent clocked SR flip-flops with a shared enable, a configurable S=R=1 policy,
// sticky conflict flags, a saturating conflict counter and a registered change pulse.
module sr_flop_bank #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned CONFLICT_MODE = 0,
  parameter bit          RESET_VAL     = 1'b0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [WIDTH-1:0] changed
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_prev;
  logic [WIDTH-1:0] conflict_d;
  logic [CNT_W-1:0] cnt_d;
  logic             hit;

  assign qbar = ~q;
  assign both = s & r;
  assign hit  = en & (|both);

  always_comb begin
    q_d = q;
    if (en) begin
      // Non-conflicting channels resolve here; conflicting ones come out 0 and are patched below.
      q_d = (q & ~r) | (s & ~r);
      case (CONFLICT_MODE)
        1:       q_d = q_d;
        2:       q_d = q_d | both;
        3:       q_d = q_d | (both & ~q);
        default: q_d = q_d | (both & q);
      endcase
    end
  end

  always_comb begin
    // A fresh conflict beats a simultaneous clear.
    conflict_d = (clr_conflict ? '0 : conflict) | (en ? both : '0);
    cnt_d      = conflict_cnt;
    if (hit) begin
      if (clr_conflict) begin
        cnt_d = CntOne;
      end else if (conflict_cnt != CntMax) begin
        cnt_d = conflict_cnt + CntOne;
      end
    end else if (clr_conflict) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q            <= {WIDTH{RESET_VAL}};
      q_prev       <= {WIDTH{RESET_VAL}};
      conflict     <= '0;
      conflict_cnt <= '0;
      changed      <= '0;
    end else begin
      q            <= q_d;
      q_prev       <= q;
      conflict     <= conflict_d;
      conflict_cnt <= cnt_d;
      // Compares the two most recent q values, so the pulse trails the q update by one edge.
      changed      <= q ^ q_prev;
    end
  end

endmodule

// File: tb/tb_sr_flop_bank.sv
// Self-checking bench for sr_flop_bank: five instances (modes 0..3, plus a 2-bit counter)
// checked every cycle against a behavioural model, with directed literal checks.
module tb_sr_flop_bank;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] s   = 8'h00;
  logic [7:0] r   = 8'h00;

  always #5 clk = ~clk;

  logic [7:0] q_w   [N];
  logic [7:0] qb_w  [N];
  logic [7:0] cf_w  [N];
  logic [7:0] cnt_w [N];
  logic [7:0] ch_w  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned MODE = (g < 4) ? g : 0;
    localparam int unsigned CW   = (g == 4) ? 2 : 8;
    logic [CW-1:0] cnt_loc;
    sr_flop_bank #(
      .WIDTH        (8),
      .CONFLICT_MODE(MODE),
      .RESET_VAL    (1'b0),
      .CNT_W        (CW)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .s           (s),
      .r           (r),
      .clr_conflict(clr),
      .q           (q_w[g]),
      .qbar        (qb_w[g]),
      .conflict    (cf_w[g]),
      .conflict_cnt(cnt_loc),
      .changed     (ch_w[g])
    );
    assign cnt_w[g] = 8'(cnt_loc);
  end

  // Behavioural model state, one entry per instance.
  logic [7:0] mq    [N];
  logic [7:0] mprev [N];
  logic [7:0] mconf [N];
  logic [7:0] mchg  [N];
  int         mcnt  [N];

  int npass  = 0;
  int ntotal = 0;

  task automatic check(input string name, input int d, input logic [7:0] act,
                       input logic [7:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s dut%0d at %0t: got %02h, want %02h", name, d, $time, act, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      mq[d] = 8'h00; mprev[d] = 8'h00; mconf[d] = 8'h00; mchg[d] = 8'h00; mcnt[d] = 0;
    end
  endtask

  task automatic model_step();
    logic [7:0] nq;
    int         mode;
    int         cmax;
    for (int d = 0; d < N; d++) begin
      mode = (d < 4) ? d : 0;
      cmax = (d == 4) ? 3 : 255;
      for (int i = 0; i < 8; i++) begin
        if (!en)                nq[i] = mq[d][i];
        else if (s[i] && r[i]) begin
          case (mode)
            1:       nq[i] = 1'b0;
            2:       nq[i] = 1'b1;
            3:       nq[i] = !mq[d][i];
            default: nq[i] = mq[d][i];
          endcase
        end
        else if (s[i])          nq[i] = 1'b1;
        else if (r[i])          nq[i] = 1'b0;
        else                    nq[i] = mq[d][i];
      end
      mchg[d]  = mq[d] ^ mprev[d];
      mprev[d] = mq[d];
      mq[d]    = nq;
      if (clr) mconf[d] = 8'h00;
      if (en)  mconf[d] = mconf[d] | (s & r);
      if (en && ((s & r) != 8'h00)) mcnt[d] = clr ? 1 : ((mcnt[d] < cmax) ? mcnt[d] + 1 : cmax);
      else if (clr)                 mcnt[d] = 0;
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
      #1;
      for (int d = 0; d < N; d++) begin
        check("q",        d, q_w[d],   mq[d]);
        check("qbar",     d, qb_w[d],  ~mq[d]);
        check("conflict", d, cf_w[d],  mconf[d]);
        check("cnt",      d, cnt_w[d], 8'(mcnt[d]));
        check("changed",  d, ch_w[d],  mchg[d]);
      end
    end
  end

  task automatic drive(input logic [7:0] sv, input logic [7:0] rv, input logic ev,
                       input logic cv);
    s = sv; r = rv; en = ev; clr = cv;
    @(posedge clk);
    #3;
  endtask

  int exp_cnt [5] = '{1, 2, 3, 3, 3};

  initial begin
    #12 rst = 1'b1;
    check("rst_q",       0, q_w[0],   8'h00);
    check("rst_qbar",    0, qb_w[0],  8'hFF);
    check("rst_cnt",     0, cnt_w[0], 8'h00);
    check("rst_changed", 0, ch_w[0],  8'h00);

    drive(8'h0F, 8'h00, 1'b1, 1'b0);
    check("basic_q1",    0, q_w[0],  8'h0F);
    check("basic_qbar1", 0, qb_w[0], 8'hF0);
    check("basic_chg1",  0, ch_w[0], 8'h00);
    drive(8'h00, 8'h03, 1'b1, 1'b0);
    check("basic_q2",    0, q_w[0],  8'h0C);
    check("basic_qbar2", 0, qb_w[0], 8'hF3);
    check("basic_chg2",  0, ch_w[0], 8'h0F);
    drive(8'h00, 8'h00, 1'b1, 1'b0);
    check("basic_chg3",  0, ch_w[0], 8'h03);

    drive(8'h01, 8'h01, 1'b1, 1'b0);
    check("mode0_q", 0, q_w[0], 8'h0C);
    check("mode1_q", 1, q_w[1], 8'h0C);
    check("mode2_q", 2, q_w[2], 8'h0D);
    check("mode3_q", 3, q_w[3], 8'h0D);
    for (int d = 0; d < 4; d++) begin
      check("mode_conflict", d, cf_w[d],  8'h01);
      check("mode_cnt",      d, cnt_w[d], 8'h01);
    end
    drive(8'h01, 8'h01, 1'b1, 1'b0);
    check("toggle_q2", 3, q_w[3], 8'h0C);
    drive(8'h01, 8'h01, 1'b1, 1'b0);
    check("toggle_q3", 3, q_w[3], 8'h0D);
    check("toggle_chg", 3, ch_w[3], 8'h01);

    drive(8'h00, 8'h00, 1'b1, 1'b1);
    check("clr_cnt",      4, cnt_w[4], 8'h00);
    check("clr_conflict", 4, cf_w[4],  8'h00);
    for (int k = 0; k < 5; k++) begin
      drive(8'h81, 8'h81, 1'b1, 1'b0);
      check("sat_cnt", 4, cnt_w[4], 8'(exp_cnt[k]));
    end
    drive(8'h80, 8'h80, 1'b1, 1'b1);
    check("clr_hit_cnt",      4, cnt_w[4], 8'h01);
    check("clr_hit_conflict", 4, cf_w[4],  8'h80);
    check("clr_hit_cnt8",     0, cnt_w[0], 8'h01);

    for (int k = 0; k < 5; k++) begin
      drive(8'hFF, 8'hFF, 1'b0, 1'b0);
      check("gate_q",        0, q_w[0],   8'h0C);
      check("gate_conflict", 0, cf_w[0],  8'h80);
      check("gate_cnt",      0, cnt_w[0], 8'h01);
      check("gate_changed",  0, ch_w[0],  8'h00);
    end

    drive(8'hA5, 8'h5A, 1'b1, 1'b0);
    drive(8'hFF, 8'hFF, 1'b1, 1'b0);
    check("pre_rst_q",        0, q_w[0],  8'hA5);
    check("pre_rst_conflict", 0, cf_w[0], 8'hFF);
    check("pre_rst_changed",  0, ch_w[0], 8'hA9);
    #2 rst = 1'b0;
    #1;
    check("async_q",        0, q_w[0],   8'h00);
    check("async_conflict", 0, cf_w[0],  8'h00);
    check("async_cnt",      0, cnt_w[0], 8'h00);
    check("async_changed",  0, ch_w[0],  8'h00);
    #2 rst = 1'b1;
    drive(8'h01, 8'h00, 1'b1, 1'b0);
    check("post_rst_q", 0, q_w[0], 8'h01);
    drive(8'h00, 8'h00, 1'b1, 1'b0);
    check("post_rst_chg", 0, ch_w[0], 8'h01);

    repeat (400) begin
      s   = 8'($urandom) & 8'($urandom);
      r   = 8'($urandom) & 8'($urandom);
      en  = ($urandom_range(3) != 0);
      clr = ($urandom_range(15) == 0);
      if ($urandom_range(79) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
      @(posedge clk);
      #3;
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
